// File: rtl/hazard_ctrl_sb_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_sb_if
//  Description : ID-stage hazard inputs and stall/refresh outputs of the
//                scoreboard stall/flush controller.
//  Revision    : 1.0
// ============================================================================
interface hazard_ctrl_sb_if #(
    parameter int RW = 5,
    parameter int NB = 4
);
    logic          id_valid;
    logic          id_branch;
    logic          id_rs_ren;
    logic [RW-1:0] id_rs;
    logic          id_rt_ren;
    logic [RW-1:0] id_rt;
    logic          id_wen;
    logic [RW-1:0] id_wreg;
    logic [1:0]    id_wclass;
    logic          id_md_use;
    logic          md_busy;
    logic          imem_wait;
    logic          dmem_wait;
    logic          exc_oc;
    logic [NB-1:0] stall;
    logic [NB-1:0] refresh;
    logic          pc_stall;
    logic          id_hazard;
    logic          exc_pend;
    logic [31:0]   stall_cnt;

    modport master (
        output id_valid, id_branch, id_rs_ren, id_rs, id_rt_ren, id_rt,
               id_wen, id_wreg, id_wclass, id_md_use, md_busy,
               imem_wait, dmem_wait, exc_oc,
        input  stall, refresh, pc_stall, id_hazard, exc_pend, stall_cnt
    );

    modport slave (
        input  id_valid, id_branch, id_rs_ren, id_rs, id_rt_ren, id_rt,
               id_wen, id_wreg, id_wclass, id_md_use, md_busy,
               imem_wait, dmem_wait, exc_oc,
        output stall, refresh, pc_stall, id_hazard, exc_pend, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_sb.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_sb
//  Description : Scoreboard-based pipeline stall/flush controller with
//                memory freeze, mul/div interlock and pending exception flush.
//  Revision    : 1.0
// ============================================================================
module hazard_ctrl_sb #(
    parameter int NSTAGE   = 5,
    parameter int NREG     = 32,
    parameter int RW       = 5,
    parameter int CW       = 3,
    parameter int LAT_ALU  = 1,
    parameter int LAT_LOAD = 2,
    parameter int LAT_CP0  = 2,
    parameter int LAT_MD   = 1,
    parameter int EXC_BND  = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    hazard_ctrl_sb_if.slave  bus
);
    localparam int NB     = NSTAGE - 1;
    localparam int C_CMAX = (1 << CW) - 1;

    function automatic logic [CW-1:0] clip_lat(input int lat);
        return (lat > C_CMAX) ? CW'(C_CMAX) : CW'(lat);
    endfunction

    localparam logic [CW-1:0] c_lat_alu  = clip_lat(LAT_ALU);
    localparam logic [CW-1:0] c_lat_load = clip_lat(LAT_LOAD);
    localparam logic [CW-1:0] c_lat_cp0  = clip_lat(LAT_CP0);
    localparam logic [CW-1:0] c_lat_md   = clip_lat(LAT_MD);

    logic [CW-1:0] r_cnt [NREG];
    logic [CW-1:0] w_dec [NREG];
    logic          r_exc_pend;
    logic [31:0]   r_stall_cnt;

    logic          w_freeze, w_flush, w_src_hz, w_hz, w_issue;
    logic [CW-1:0] w_slack, w_lat, w_wr_val;

    assign w_freeze = bus.dmem_wait;
    assign w_flush  = !w_freeze && (bus.exc_oc || r_exc_pend);
    // Branches resolve in ID and so need the value one cycle earlier.
    assign w_slack  = bus.id_branch ? '0 : CW'(1);
    assign w_src_hz = (bus.id_rs_ren && (bus.id_rs != '0) && (r_cnt[bus.id_rs] > w_slack)) ||
                      (bus.id_rt_ren && (bus.id_rt != '0) && (r_cnt[bus.id_rt] > w_slack));
    assign w_hz     = bus.id_valid && !w_freeze && !w_flush &&
                      (w_src_hz || (bus.id_md_use && bus.md_busy));
    assign w_issue  = bus.id_valid && bus.id_wen && (bus.id_wreg != '0) &&
                      !w_hz && !w_freeze && !w_flush;

    always_comb begin
        w_lat = c_lat_alu;
        case (bus.id_wclass)
            2'd0:    w_lat = c_lat_alu;
            2'd1:    w_lat = c_lat_load;
            2'd2:    w_lat = c_lat_cp0;
            default: w_lat = c_lat_md;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_dec[i] = (r_cnt[i] == '0) ? '0 : r_cnt[i] - CW'(1);
        end
    end

    // Keep the longer of an older writer's remaining time and the new latency (WAW).
    assign w_wr_val = (w_dec[bus.id_wreg] > w_lat) ? w_dec[bus.id_wreg] : w_lat;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
        end else if (w_freeze) begin
            for (int i = 0; i < NREG; i++) r_cnt[i] <= r_cnt[i];
        end else if (w_flush) begin
            for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
        end else begin
            r_cnt[0] <= '0;
            for (int i = 1; i < NREG; i++) begin
                if (w_issue && (bus.id_wreg == RW'(i))) r_cnt[i] <= w_wr_val;
                else                                    r_cnt[i] <= w_dec[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exc_pend  <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (w_flush)                      r_exc_pend <= 1'b0;
            else if (bus.exc_oc && w_freeze)  r_exc_pend <= 1'b1;
            if (w_freeze || w_hz)             r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    always_comb begin
        bus.stall    = '0;
        bus.refresh  = '0;
        bus.pc_stall = 1'b0;
        if (w_freeze) begin
            bus.stall    = '1;
            bus.pc_stall = 1'b1;
        end else if (w_flush) begin
            for (int i = 0; i < NB; i++) bus.refresh[i] = (i <= EXC_BND);
        end else if (w_hz) begin
            bus.stall[0]   = 1'b1;
            bus.refresh[1] = 1'b1;
            bus.pc_stall   = 1'b1;
        end else if (bus.imem_wait) begin
            bus.refresh[0] = 1'b1;
            bus.pc_stall   = 1'b1;
        end
    end

    assign bus.id_hazard = w_hz;
    assign bus.exc_pend  = r_exc_pend;
    assign bus.stall_cnt = r_stall_cnt;
endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl_sb
//  Description : Directed vector bench for hazard_ctrl_sb.
//  Revision    : 1.0
// ============================================================================
module tb_hazard_ctrl_sb;
    localparam int c_n = 0;  // normal
    localparam int c_f = 1;  // freeze
    localparam int c_x = 2;  // flush
    localparam int c_h = 3;  // ID interlock
    localparam int c_i = 4;  // fetch wait

    typedef struct {
        logic        rst, v, br;
        logic [4:0]  rs, rt;
        logic        wen;
        logic [4:0]  wreg;
        logic [1:0]  wc;
        logic        mdu, mdb, imw, dmw, exc;
        logic [3:0]  e_stall, e_ref;
        logic        e_pc, e_hz, e_pend;
        logic [31:0] e_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    hazard_ctrl_sb_if #(.RW(5), .NB(4)) bus ();

    hazard_ctrl_sb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic vec_t mk(input logic r, v, br, input logic [4:0] rs, rt,
                                input logic wen, input logic [4:0] wreg, input logic [1:0] wc,
                                input logic mdu, mdb, imw, dmw, exc,
                                input int code, input logic pend, input int cnt);
        vec_t t;
        t.rst = r; t.v = v; t.br = br; t.rs = rs; t.rt = rt; t.wen = wen;
        t.wreg = wreg; t.wc = wc; t.mdu = mdu; t.mdb = mdb; t.imw = imw;
        t.dmw = dmw; t.exc = exc; t.e_pend = pend; t.e_cnt = cnt;
        case (code)
            c_f:     begin t.e_stall = 4'b1111; t.e_ref = 4'b0000; t.e_pc = 1'b1; t.e_hz = 1'b0; end
            c_x:     begin t.e_stall = 4'b0000; t.e_ref = 4'b0111; t.e_pc = 1'b0; t.e_hz = 1'b0; end
            c_h:     begin t.e_stall = 4'b0001; t.e_ref = 4'b0010; t.e_pc = 1'b1; t.e_hz = 1'b1; end
            c_i:     begin t.e_stall = 4'b0000; t.e_ref = 4'b0001; t.e_pc = 1'b1; t.e_hz = 1'b0; end
            default: begin t.e_stall = 4'b0000; t.e_ref = 4'b0000; t.e_pc = 1'b0; t.e_hz = 1'b0; end
        endcase
        return t;
    endfunction

    task automatic apply(input vec_t t);
        @(posedge clk);
        #1;
        rst = t.rst;
        bus.id_valid = t.v;   bus.id_branch = t.br;
        bus.id_rs_ren = t.v;  bus.id_rs = t.rs;
        bus.id_rt_ren = t.v;  bus.id_rt = t.rt;
        bus.id_wen = t.wen;   bus.id_wreg = t.wreg;  bus.id_wclass = t.wc;
        bus.id_md_use = t.mdu; bus.md_busy = t.mdb;
        bus.imem_wait = t.imw; bus.dmem_wait = t.dmw; bus.exc_oc = t.exc;
        @(negedge clk);
        n_vec++;
        if (bus.stall !== t.e_stall || bus.refresh !== t.e_ref || bus.pc_stall !== t.e_pc ||
            bus.id_hazard !== t.e_hz || bus.exc_pend !== t.e_pend || bus.stall_cnt !== t.e_cnt) begin
            n_bad++;
            $display("FAIL vec%0d: got stall=%b refresh=%b pc_stall=%b id_hazard=%b exc_pend=%b stall_cnt=%0d; want %b %b %b %b %b %0d",
                     n_vec - 1, bus.stall, bus.refresh, bus.pc_stall, bus.id_hazard, bus.exc_pend,
                     bus.stall_cnt, t.e_stall, t.e_ref, t.e_pc, t.e_hz, t.e_pend, t.e_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.id_valid = 0; bus.id_branch = 0; bus.id_rs_ren = 0; bus.id_rs = 0;
        bus.id_rt_ren = 0; bus.id_rt = 0; bus.id_wen = 0; bus.id_wreg = 0;
        bus.id_wclass = 0; bus.id_md_use = 0; bus.md_busy = 0;
        bus.imem_wait = 0; bus.dmem_wait = 0; bus.exc_oc = 0;
        repeat (2) @(posedge clk);

        //                 r v br rs rt we wr wc mu mb iw dw ex  out pend cnt
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0, 0,0,0,0,0, c_n,0, 0));  // reset state
        tbl.push_back(mk(0,1,0, 0,0, 1,5,1, 0,0,0,0,0, c_n,0, 0));  // lw r5
        tbl.push_back(mk(0,1,0, 5,0, 1,6,0, 0,0,0,0,0, c_h,0, 0));  // load-use
        tbl.push_back(mk(0,1,0, 5,0, 1,6,0, 0,0,0,0,0, c_n,0, 1));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0, 0,0,0,0,0, c_n,0, 1));
        tbl.push_back(mk(0,1,0, 0,0, 1,5,1, 0,0,0,0,0, c_n,0, 1));  // lw r5
        tbl.push_back(mk(0,1,1, 5,0, 0,0,0, 0,0,0,0,0, c_h,0, 1));  // beq r5: 2 stalls
        tbl.push_back(mk(0,1,1, 5,0, 0,0,0, 0,0,0,0,0, c_h,0, 2));
        tbl.push_back(mk(0,1,1, 5,0, 0,0,0, 0,0,0,0,0, c_n,0, 3));
        tbl.push_back(mk(0,1,0, 0,0, 1,6,0, 0,0,0,0,0, c_n,0, 3));  // addu r6
        tbl.push_back(mk(0,1,1, 6,0, 0,0,0, 0,0,0,0,0, c_h,0, 3));  // beq r6: 1 stall
        tbl.push_back(mk(0,1,1, 6,0, 0,0,0, 0,0,0,0,0, c_n,0, 4));
        tbl.push_back(mk(0,1,0, 0,0, 1,6,0, 0,0,0,0,0, c_n,0, 4));  // addu r6
        tbl.push_back(mk(0,1,0, 6,0, 1,8,0, 0,0,0,0,0, c_n,0, 4));  // addu reads r6: none
        tbl.push_back(mk(0,1,0, 0,0, 1,7,1, 0,0,0,0,0, c_n,0, 4));  // lw r7
        tbl.push_back(mk(0,1,0, 0,0, 1,7,0, 0,0,0,0,0, c_n,0, 4));  // addu r7 (WAW)
        tbl.push_back(mk(0,1,1, 7,0, 0,0,0, 0,0,0,0,0, c_h,0, 4));
        tbl.push_back(mk(0,1,1, 7,0, 0,0,0, 0,0,0,0,0, c_n,0, 5));
        tbl.push_back(mk(0,1,0, 0,0, 1,9,1, 0,0,0,0,0, c_n,0, 5));  // lw r9
        tbl.push_back(mk(0,1,0, 0,9, 0,0,0, 0,0,0,0,0, c_h,0, 5));  // rt use
        tbl.push_back(mk(0,1,0, 0,9, 0,0,0, 0,0,0,0,0, c_n,0, 6));
        tbl.push_back(mk(0,1,0, 0,0, 1,5,1, 0,0,0,0,0, c_n,0, 6));  // lw r5
        tbl.push_back(mk(0,1,0, 5,0, 0,0,0, 0,0,0,1,0, c_f,0, 6));  // freeze x3
        tbl.push_back(mk(0,1,0, 5,0, 0,0,0, 0,0,0,1,0, c_f,0, 7));
        tbl.push_back(mk(0,1,0, 5,0, 0,0,0, 0,0,0,1,0, c_f,0, 8));
        tbl.push_back(mk(0,1,0, 5,0, 0,0,0, 0,0,0,0,0, c_h,0, 9));  // counters were held
        tbl.push_back(mk(0,1,0, 5,0, 0,0,0, 0,0,0,0,0, c_n,0,10));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0, 0,0,1,0,0, c_i,0,10));  // fetch wait
        tbl.push_back(mk(0,1,0, 0,0, 1,5,1, 0,0,1,0,0, c_i,0,10));  // lw issues under imem_wait
        tbl.push_back(mk(0,1,0, 5,0, 0,0,0, 0,0,1,0,0, c_h,0,10));  // hazard beats imem_wait
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0, 0,0,0,0,0, c_n,0,11));
        tbl.push_back(mk(0,1,0, 0,0, 1,5,1, 0,0,0,0,0, c_n,0,11));  // lw r5
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0, 0,0,0,1,1, c_f,0,11));  // exc during freeze
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0, 0,0,0,1,0, c_f,1,12));
        tbl.push_back(mk(0,1,0, 5,0, 0,0,0, 0,0,0,0,0, c_x,1,13));  // pending flush
        tbl.push_back(mk(0,1,1, 5,0, 0,0,0, 0,0,0,0,0, c_n,0,13));  // counters cleared
        tbl.push_back(mk(0,1,0, 0,0, 1,5,1, 0,0,0,0,0, c_n,0,13));  // lw r5
        tbl.push_back(mk(0,1,0, 5,0, 0,0,0, 0,0,1,0,1, c_x,0,13));  // direct flush
        tbl.push_back(mk(0,1,1, 5,0, 0,0,0, 0,0,0,0,0, c_n,0,13));
        tbl.push_back(mk(0,1,0, 0,0, 1,0,1, 0,0,0,0,0, c_n,0,13));  // lw r0: untracked
        tbl.push_back(mk(0,1,1, 0,0, 0,0,0, 0,0,0,0,0, c_n,0,13));
        tbl.push_back(mk(0,1,0, 0,0, 0,0,0, 1,1,0,0,0, c_h,0,13));  // md interlock
        tbl.push_back(mk(0,1,0, 0,0, 0,0,0, 1,1,0,0,0, c_h,0,14));
        tbl.push_back(mk(0,1,0, 0,0, 0,0,0, 1,0,0,0,0, c_n,0,15));
        tbl.push_back(mk(0,1,0, 0,0, 0,0,0, 0,1,0,0,0, c_n,0,15));
        tbl.push_back(mk(0,1,0, 0,0, 1,5,1, 0,0,0,0,0, c_n,0,15));  // lw r5
        tbl.push_back(mk(0,1,1, 5,0, 0,0,0, 0,0,0,0,0, c_h,0,15));
        tbl.push_back(mk(0,1,1, 5,0, 0,0,0, 0,0,0,1,1, c_f,0,16));
        tbl.push_back(mk(1,1,1, 5,0, 0,0,0, 0,0,0,1,0, c_f,1,17));  // reset mid-hazard
        tbl.push_back(mk(0,1,1, 5,0, 0,0,0, 0,0,0,0,0, c_n,0, 0));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0, 0,0,0,0,0, c_n,0, 0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Repeated exc_oc while pending keeps it set until the freeze lifts.
        apply(mk(0,0,0, 0,0, 0,0,0, 0,0,0,1,1, c_f,0, 0));
        apply(mk(0,0,0, 0,0, 0,0,0, 0,0,0,1,1, c_f,1, 1));
        apply(mk(0,0,0, 0,0, 0,0,0, 0,0,0,1,0, c_f,1, 2));
        apply(mk(0,0,0, 0,0, 0,0,0, 0,0,0,0,0, c_x,1, 3));
        apply(mk(0,0,0, 0,0, 0,0,0, 0,0,0,0,0, c_n,0, 3));

        // Long mul/div busy window.
        for (int k = 0; k < 5; k++) apply(mk(0,1,0, 0,0, 0,0,0, 1,1,0,0,0, c_h,0, 3 + k));
        apply(mk(0,1,0, 0,0, 0,0,0, 1,0,0,0,0, c_n,0, 8));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/hazard_ctrl_sb.md
Name: hazard_ctrl_sb

Overview:
- Parametrised, scoreboard-based pipeline stall/flush controller for the in-order MIPS pipeline.
- Replaces purely combinational stage-compare hazard detection. It tracks, per architectural register, the cycles remaining until a pending result can be forwarded to ID.
- Adds memory-wait freeze, multicycle mul/div interlock, and an exception flush that is held pending across a freeze.
- Outputs are per-boundary stall/refresh vectors plus a lost-cycle performance counter.

Parameters:
NSTAGE, 5, pipeline stages (0=IF,1=ID,2=EX,...); boundary i sits between stage i and i+1; NB=NSTAGE-1 boundaries
NREG, 32, architectural registers tracked; register 0 never tracked
RW, 5, register index width (clog2 NREG)
CW, 3, scoreboard counter width
LAT_ALU, 1, ready delay for class 0 (ALU)
LAT_LOAD, 2, ready delay for class 1 (load)
LAT_CP0, 2, ready delay for class 2 (mfc0/mfhi/mflo)
LAT_MD, 1, ready delay for class 3 (mul/div GPR write)
EXC_BND, 2, highest boundary cleared on exception flush (boundaries 0..EXC_BND)

Ports:
clk  in  1  clock
rst  in  1  reset
id_valid  in  1  valid instruction in ID
id_branch  in  1  ID instruction resolves in ID (needs operands in ID)
id_rs_ren  in  1  ID reads rs
id_rs  in  RW  rs index
id_rt_ren  in  1  ID reads rt
id_rt  in  RW  rt index
id_wen  in  1  ID instruction writes a GPR
id_wreg  in  RW  destination index
id_wclass  in  2  writer class 0..3
id_md_use  in  1  ID instruction issues mul/div or reads HI/LO
md_busy  in  1  mul/div unit busy
imem_wait  in  1  fetch not ready this cycle
dmem_wait  in  1  data access outstanding; freeze whole pipeline
exc_oc  in  1  exception/eret taken
stall  out  NB  bit i: boundary i holds its contents
refresh  out  NB  bit i: boundary i loads a bubble
pc_stall  out  1  PC holds
id_hazard  out  1  ID held by a data/md interlock
exc_pend  out  1  flush latched, waiting for freeze release
stall_cnt  out  32  cycles lost to freeze or ID interlock

Behaviour:
- Clock and reset:
  - One clock, clk. rst is synchronous and active-high.
  - On reset: all counters cnt[1..NREG-1]=0, exc_pend=0, stall_cnt=0.
  - Outputs are combinational from state and inputs. With idle inputs after reset: stall=0, refresh=0, pc_stall=0, id_hazard=0.
- Derived terms:
  - freeze = dmem_wait.
  - flush = !freeze && (exc_oc || exc_pend).
  - slack = id_branch ? 0 : 1.
  - src_hz = (id_rs_ren && id_rs!=0 && cnt[id_rs]>slack) || (id_rt_ren && id_rt!=0 && cnt[id_rt]>slack).
  - id_hazard = id_valid && !freeze && !flush && (src_hz || (id_md_use && md_busy)).
- Control outputs, priority freeze > flush > id_hazard > imem_wait > normal:
  - freeze: stall=all ones, refresh=0, pc_stall=1.
  - flush: stall=0, refresh bits 0..EXC_BND=1, higher bits=0, pc_stall=0 (PC loads vector externally).
  - id_hazard: stall bit0=1, refresh bit1=1, pc_stall=1, all other bits 0.
  - imem_wait: refresh bit0=1, pc_stall=1.
  - normal: all outputs 0.
- Scoreboard update each clock edge:
  - On freeze: hold all counters.
  - On flush: clear all counters. This is safe because the first post-flush instruction reaches ID at least 2 cycles later, by which time older writers have finished.
  - Otherwise: every nonzero counter decrements by 1.
  - Issue occurs when id_valid && id_wen && id_wreg!=0 && !id_hazard && !freeze && !flush. On issue, cnt[id_wreg] = max(cnt[id_wreg]-1 saturated at 0, LAT[id_wclass]). The max protects against WAW with a longer-latency older writer.
  - The issuing instruction never hazards against its own destination.
  - Latency values are clipped to 2^CW-1.
- exc_pend:
  - Set when exc_oc && freeze.
  - Cleared on any cycle where flush is asserted.
  - A further exc_oc while pending leaves it set.
- stall_cnt:
  - Increments when freeze || id_hazard; wraps 2^32-1 to 0.
  - Holds during flush.

Test Plan:
- Load-use: issue lw r5 (class1); next cycle ID addu reading r5 -> id_hazard=1 for 1 cycle (stall=0001, refresh=0010, pc_stall=1), then proceeds; stall_cnt=1.
- Load then branch: lw r5, then beq reading r5 -> id_hazard 2 cycles; addu r6 then beq r6 -> 1 cycle; addu r6 then addu reading r6 -> no stall.
- WAW: lw r7 then addu r7 back-to-back -> cnt[r7] stays at load latency path (max rule); consumer of r7 still stalls 1 cycle.
- Freeze: dmem_wait=1 for 3 cycles with pending load hazard -> stall=1111, refresh=0, counters frozen; hazard resolves on the same relative cycle after release; stall_cnt +=3 plus hazard cycles.
- Exception during freeze: exc_oc pulse while dmem_wait=1 -> exc_pend=1, no refresh. Cycle after dmem_wait drops -> refresh=0111, stall=0, counters cleared, exc_pend=0.
- Mul/div interlock and reset: md_busy=1 with id_md_use=1 -> id_hazard held until md_busy falls. Assert rst mid-hazard -> next cycle counters=0, exc_pend=0, stall_cnt=0, id_hazard=0.
